// File: rtl/cavlc_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_scan_pkg
// Description : Shared constants for the CAVLC scan feeder: scan-state codes
//               (same encoding as the downstream total-coeff counter),
//               block-mode codes and the 4x4 frame/field scan tables.
//               The field table is only referenced when CAVLC_FIELD_SCAN_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package cavlc_scan_pkg;

    // Scan-state codes, shared with the downstream counter
    localparam logic [3:0] SCAN_INIT   = 4'd0;
    localparam logic [3:0] SCAN_CYCLE0 = 4'd1;
    localparam logic [3:0] SCAN_CYCLE1 = 4'd2;
    localparam logic [3:0] SCAN_CYCLE2 = 4'd3;
    localparam logic [3:0] SCAN_CYCLE3 = 4'd4;
    localparam logic [3:0] SCAN_CYCLE4 = 4'd5;
    localparam logic [3:0] SCAN_CYCLE5 = 4'd6;
    localparam logic [3:0] SCAN_CYCLE6 = 4'd7;
    localparam logic [3:0] SCAN_CYCLE7 = 4'd8;

    // Block modes sampled with an accepted start
    localparam logic [1:0] MODE_4x4 = 2'd0;
    localparam logic [1:0] MODE_AC  = 2'd1;
    localparam logic [1:0] MODE_CDC = 2'd2;
    localparam logic [1:0] MODE_LDC = 2'd3;

    // Scan tables packed as 16 nibbles; nibble p holds the raster address of
    // scan position p (position 0 in the least significant nibble).
    // Frame : 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15
    localparam logic [63:0] FRAME_TBL = 64'hFEB7_ADC9_6325_8410;
    // Field : 0,4,1,8,12,5,9,13,2,6,10,14,3,7,11,15
    localparam logic [63:0] FIELD_TBL = 64'hFB73_EA62_D95C_8140;

    function automatic logic [3:0] tbl_lookup(input logic [63:0] tbl,
                                              input logic [3:0]  pos);
        return tbl[{pos, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_scan_rom.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_scan_rom
// Description : Combinational scan-position to raster-address map.
//               Frame zig-zag always; field order selectable only when
//               CAVLC_FIELD_SCAN_EN is defined.
// Ports       : i_pos   - scan position 0..15
//               i_field - select field order (CAVLC_FIELD_SCAN_EN only)
//               o_addr  - raster address row*4+col
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_scan_rom
    import cavlc_scan_pkg::*;
(
    input  logic [3:0] i_pos,
`ifdef CAVLC_FIELD_SCAN_EN
    input  logic       i_field,
`endif
    output logic [3:0] o_addr
);

    always_comb begin
        o_addr = tbl_lookup(FRAME_TBL, i_pos);
`ifdef CAVLC_FIELD_SCAN_EN
        if (i_field) begin
            o_addr = tbl_lookup(FIELD_TBL, i_pos);
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/cavlc_scan_feeder.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_scan_feeder
// Description : Ping-pong 4x4 coefficient store that replays a block in
//               reverse zig-zag order, two coefficients per cycle, over eight
//               scan cycles, with the scan-state code for the CAVLC counter.
// Ports       : clk, rst (async, active-high)
//               wr_en/wr_addr/wr_data - load-bank write port
//               start/blk_mode[/field_scan] - begin scan (when ready)
//               ready     - start accepted this cycle
//               state     - 0 = INIT, 1..8 = scan cycle 0..7
//               s_all     - non-zero flags of {coef1, coef0}
//               coef0/1   - scan positions 15-2k / 14-2k in cycle k
//               blk_done  - pulse with scan cycle 7
// Config      : CAVLC_FIELD_SCAN_EN adds field_scan and the field table.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_scan_feeder
    import cavlc_scan_pkg::*;
#(
    parameter int COEF_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     start,
    input  logic [1:0]               blk_mode,
`ifdef CAVLC_FIELD_SCAN_EN
    input  logic                     field_scan,
`endif
    output logic                     ready,
    output logic [3:0]               state,
    output logic [1:0]               s_all,
    output logic signed [COEF_W-1:0] coef0,
    output logic signed [COEF_W-1:0] coef1,
    output logic                     blk_done
);

    logic [3:0]               r_state;
    logic [3:0]               w_state_nxt;
    logic                     r_ld_bank;
    logic                     r_rd_bank;
    logic                     w_rd_bank_nxt;
    logic [1:0]               r_mode;
    logic [1:0]               w_mode_nxt;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_scan_active;
    logic [2:0]               w_k;
    logic signed [COEF_W-1:0] r_bank [2][16];
    logic signed [COEF_W-1:0] w_lane_val [2];

`ifdef CAVLC_FIELD_SCAN_EN
    logic r_field;
    logic w_field_nxt;
    assign w_field_nxt = w_accept ? field_scan : r_field;
`endif

    assign w_ready  = (r_state == SCAN_INIT) || (r_state == SCAN_CYCLE7);
    assign w_accept = start && w_ready;
    assign ready    = w_ready;
    assign state    = r_state;

    always_comb begin
        w_state_nxt = SCAN_INIT;
        if (w_accept) begin
            w_state_nxt = SCAN_CYCLE0;
        end else if ((r_state >= SCAN_CYCLE0) && (r_state < SCAN_CYCLE7)) begin
            w_state_nxt = r_state + 4'd1;
        end
    end

    // Outputs are registered, so the pair is selected from the state, mode and
    // bank that will be current after this edge.
    assign w_rd_bank_nxt = w_accept ? r_ld_bank : r_rd_bank;
    assign w_mode_nxt    = w_accept ? blk_mode  : r_mode;
    assign w_scan_active = (w_state_nxt != SCAN_INIT);
    assign w_k           = w_state_nxt[2:0] - 3'd1;

    // Lane 0 shows position 15-2k, lane 1 shows 14-2k.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam logic c_pos_lsb = (gi == 0) ? 1'b1 : 1'b0;
        logic [3:0]               w_pos;
        logic [3:0]               w_rom_addr;
        logic [3:0]               w_addr;
        logic signed [COEF_W-1:0] w_raw;
        logic                     w_force_zero;

        assign w_pos = {~w_k, c_pos_lsb};

        cavlc_scan_rom u_rom (
            .i_pos   (w_pos),
`ifdef CAVLC_FIELD_SCAN_EN
            .i_field (w_field_nxt),
`endif
            .o_addr  (w_rom_addr)
        );

        // Chroma DC is stored linearly at addresses 0..3.
        assign w_addr = (w_mode_nxt == MODE_CDC) ? w_pos : w_rom_addr;

        // A write in the start cycle belongs to the frozen bank, so it has to
        // be forwarded into the first registered pair.
        assign w_raw = (wr_en && (r_ld_bank == w_rd_bank_nxt) && (wr_addr == w_addr))
                     ? wr_data : r_bank[w_rd_bank_nxt][w_addr];

        assign w_force_zero = !w_scan_active
                           || ((w_mode_nxt == MODE_AC)  && (w_pos == 4'd0))
                           || ((w_mode_nxt == MODE_CDC) && (w_pos[3:2] != 2'b00));

        assign w_lane_val[gi] = w_force_zero ? '0 : w_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SCAN_INIT;
            r_ld_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_mode    <= MODE_4x4;
`ifdef CAVLC_FIELD_SCAN_EN
            r_field   <= 1'b0;
`endif
            s_all     <= 2'b00;
            coef0     <= '0;
            coef1     <= '0;
            blk_done  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < 16; a++) begin
                    r_bank[b][a] <= '0;
                end
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mode    <= blk_mode;
                r_rd_bank <= r_ld_bank;
                r_ld_bank <= ~r_ld_bank;
`ifdef CAVLC_FIELD_SCAN_EN
                r_field   <= field_scan;
`endif
            end
            if (wr_en) begin
                r_bank[r_ld_bank][wr_addr] <= wr_data;
            end
            coef0    <= w_lane_val[0];
            coef1    <= w_lane_val[1];
            s_all    <= {(w_lane_val[1] != '0), (w_lane_val[0] != '0)};
            blk_done <= (w_state_nxt == SCAN_CYCLE7);
        end
    end

endmodule
`default_nettype wire
